// File: rtl/lvds_rx_deframer_if.sv
// Sample-side and pixel-side bundle of the LVDS receive deframer.
// The master is the upstream sampling stage and the slave is the deframer.
interface lvds_rx_deframer_if #(
   parameter int ERR_W = 16
);
   logic             bit_valid;
   logic             clk_lane;
   logic [3:0]       data_lane;
   logic             pix_valid;
   logic [7:0]       red;
   logic [7:0]       green;
   logic [7:0]       blue;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic             locked;
   logic [ERR_W-1:0] align_err_cnt;

   modport master (
      output bit_valid, clk_lane, data_lane,
      input  pix_valid, red, green, blue, hsync, vsync, de, locked, align_err_cnt
   );

   modport slave (
      input  bit_valid, clk_lane, data_lane,
      output pix_valid, red, green, blue, hsync, vsync, de, locked, align_err_cnt
   );
endinterface

// File: rtl/lvds_rx_deframer.sv
// 4-lane LVDS receive deframer: clock-lane word alignment, deserialization, RGB/HS/VS/DE unpack.
// Define LVDS_RX_JEIDA_EN for the JEIDA bit mapping; the default build uses the VESA mapping.
module lvds_rx_deframer #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   lvds_rx_deframer_if.slave  rx
);

   localparam logic [6:0] CLK_WORD = 7'b1100011;
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t            state, state_next;
   logic [MW-1:0]     match_cnt, match_next;
   logic [LW-1:0]     miss_cnt, miss_next;
   logic [2:0]        phase, phase_next;
   logic [2:0]        fill;
   logic [6:0]        clk_sr;
   logic [3:0][6:0]   lane_sr;
   logic [6:0]        clk_word;
   logic [3:0][6:0]   lane_word;
   logic              clk_match;
   logic              word_full;
   logic              boundary;
   logic              pix_load;
   logic              err_inc;
   logic              locked_next;
   logic [7:0]        dec_red, dec_green, dec_blue;
   logic [ERR_W-1:0]  err_cnt;

   // Words are judged including the bit arriving this cycle, so the decision and the
   // pixel it produces register on the edge that consumes the word's last bit.
   always_comb begin
      clk_word  = {clk_sr[5:0], rx.clk_lane};
      lane_word = '0;
      for (int i = 0; i < 4; i++) begin
         lane_word[i] = {lane_sr[i][5:0], rx.data_lane[i]};
      end
      clk_match = (clk_word == CLK_WORD);
      word_full = (fill >= 3'd6);
      boundary  = rx.bit_valid && (phase == 3'd6);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sr  <= '0;
         lane_sr <= '0;
         fill    <= '0;
      end else if (rx.bit_valid) begin
         clk_sr  <= clk_word;
         lane_sr <= lane_word;
         fill    <= (fill == 3'd7) ? 3'd7 : fill + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HUNT;
         match_cnt <= '0;
         miss_cnt  <= '0;
         phase     <= '0;
      end else begin
         state     <= state_next;
         match_cnt <= match_next;
         miss_cnt  <= miss_next;
         phase     <= phase_next;
      end
   end

   // Hunting slides one bit at a time; once a candidate is found only word boundaries count.
   always_comb begin
      state_next = state;
      match_next = match_cnt;
      miss_next  = miss_cnt;
      phase_next = phase;
      if (rx.bit_valid) begin
         phase_next = (phase == 3'd6) ? 3'd0 : phase + 3'd1;
         case (state)
            HUNT: begin
               if (word_full && clk_match) begin
                  state_next = VERIFY;
                  phase_next = '0;
                  match_next = MW'(1);
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (clk_match) begin
                     match_next = match_cnt + 1'b1;
                     if (match_cnt + 1'b1 == MW'(LOCK_COUNT)) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                     end
                  end else begin
                     state_next = HUNT;
                     match_next = '0;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (clk_match) begin
                     miss_next = '0;
                  end else begin
                     miss_next = miss_cnt + 1'b1;
                     if (miss_cnt + 1'b1 == LW'(LOSS_COUNT)) begin
                        state_next = HUNT;
                        match_next = '0;
                     end
                  end
               end
            end
            default: begin
               state_next = HUNT;
               match_next = '0;
            end
         endcase
      end
   end

   always_comb begin
      pix_load    = (state == LOCKED) && boundary;
      err_inc     = pix_load && !clk_match;
      locked_next = (state_next == LOCKED);
`ifdef LVDS_RX_JEIDA_EN
      dec_red     = {lane_word[0][5:0], lane_word[3][1:0]};
      dec_green   = {lane_word[1][4:0], lane_word[0][6], lane_word[3][3:2]};
      dec_blue    = {lane_word[2][3:0], lane_word[1][6:5], lane_word[3][5:4]};
`else
      dec_red     = {lane_word[3][1:0], lane_word[0][5:0]};
      dec_green   = {lane_word[3][3:2], lane_word[1][4:0], lane_word[0][6]};
      dec_blue    = {lane_word[3][5:4], lane_word[2][3:0], lane_word[1][6:5]};
`endif
   end

   // The word that drops lock still decodes, so pixel loading ignores the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx.pix_valid <= 1'b0;
         rx.red       <= '0;
         rx.green     <= '0;
         rx.blue      <= '0;
         rx.hsync     <= 1'b0;
         rx.vsync     <= 1'b0;
         rx.de        <= 1'b0;
         rx.locked    <= 1'b0;
         err_cnt      <= '0;
      end else begin
         rx.pix_valid <= pix_load;
         rx.locked    <= locked_next;
         if (pix_load) begin
            rx.red   <= dec_red;
            rx.green <= dec_green;
            rx.blue  <= dec_blue;
            rx.hsync <= lane_word[2][4];
            rx.vsync <= lane_word[2][5];
            rx.de    <= lane_word[2][6];
         end
         if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   assign rx.align_err_cnt = err_cnt;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Randomized self-checking bench for lvds_rx_deframer against a bit-history reference model.
// Honours LVDS_RX_JEIDA_EN for the pixel-to-lane encoding it generates.
module tb_lvds_rx_deframer;

   localparam logic [6:0] CLK_WORD   = 7'b1100011;
   localparam logic [6:0] BAD_WORD   = 7'b0000000;
   localparam int         LOCK_COUNT = 4;
   localparam int         LOSS_COUNT = 3;
   localparam int         M_HUNT     = 0;
   localparam int         M_VERIFY   = 1;
   localparam int         M_LOCKED   = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       de;
   } pix_t;

   typedef struct packed {
      logic        pv;
      logic        lk;
      pix_t        px;
      logic [15:0] err;
   } snap_t;

   typedef logic [3:0][6:0] lanes_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lvds_rx_deframer_if #(.ERR_W(16)) rx();

   lvds_rx_deframer #(
      .LOCK_COUNT(LOCK_COUNT),
      .LOSS_COUNT(LOSS_COUNT),
      .ERR_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx(rx)
   );

   int    errors = 0;
   int    checks = 0;
   int    gap_mode = 0;
   snap_t obs[$];
   snap_t expq[$];

   // Reference model: remembers every received clock bit and reasons about whole words.
   logic  clk_hist[$];
   int    m_mode, m_matches, m_misses, m_pos, m_err;
   logic  m_pv;
   pix_t  m_pix;

   function automatic lanes_t encode(input pix_t p, input logic spare);
      lanes_t l;
`ifdef LVDS_RX_JEIDA_EN
      l[0] = {p.g[2], p.r[7:2]};
      l[1] = {p.b[3:2], p.g[7:3]};
      l[2] = {p.de, p.vs, p.hs, p.b[7:4]};
      l[3] = {spare, p.b[1:0], p.g[1:0], p.r[1:0]};
`else
      l[0] = {p.g[0], p.r[5:0]};
      l[1] = {p.b[1:0], p.g[5:1]};
      l[2] = {p.de, p.vs, p.hs, p.b[5:2]};
      l[3] = {spare, p.b[7:6], p.g[7:6], p.r[7:6]};
`endif
      return l;
   endfunction

   function automatic pix_t rand_pix();
      logic [31:0] v;
      v = $urandom;
      return v[26:0];
   endfunction

   task automatic model_reset();
      clk_hist.delete();
      m_mode = M_HUNT; m_matches = 0; m_misses = 0; m_pos = 0; m_err = 0;
      m_pv = 1'b0; m_pix = '0;
   endtask

   task automatic model_bit(input logic c, input pix_t tag);
      logic [6:0] w;
      int n;
      clk_hist.push_back(c);
      n = clk_hist.size();
      w = '0;
      if (n >= 7) for (int i = 0; i < 7; i++) w[6-i] = clk_hist[n-7+i];
      m_pv = 1'b0;
      if (m_mode == M_HUNT) begin
         if (n >= 7 && w == CLK_WORD) begin
            m_mode = M_VERIFY; m_matches = 1; m_pos = 0;
         end
      end else begin
         m_pos++;
         if (m_pos == 7) begin
            m_pos = 0;
            if (m_mode == M_VERIFY) begin
               if (w == CLK_WORD) begin
                  m_matches++;
                  if (m_matches == LOCK_COUNT) begin m_mode = M_LOCKED; m_misses = 0; end
               end else begin
                  m_mode = M_HUNT;
               end
            end else begin
               m_pv = 1'b1;
               m_pix = tag;
               if (w == CLK_WORD) m_misses = 0;
               else begin
                  m_misses++;
                  if (m_err < 65535) m_err++;
                  if (m_misses == LOSS_COUNT) m_mode = M_HUNT;
               end
            end
         end
      end
   endtask

   task automatic record();
      obs.push_back({rx.pix_valid, rx.locked, rx.red, rx.green, rx.blue,
                     rx.hsync, rx.vsync, rx.de, rx.align_err_cnt});
      expq.push_back({m_pv, (m_mode == M_LOCKED), m_pix, m_err[15:0]});
   endtask

   task automatic idle_cycle();
      rx.bit_valid = 1'b0;
      rx.clk_lane = 1'($urandom);
      rx.data_lane = 4'($urandom);
      @(posedge clk);
      m_pv = 1'b0;
      #1;
      record();
   endtask

   task automatic send_bit(input logic c, input logic [3:0] d, input pix_t tag);
      int gaps;
      rx.bit_valid = 1'b1;
      rx.clk_lane = c;
      rx.data_lane = d;
      @(posedge clk);
      model_bit(c, tag);
      #1;
      record();
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int i = 0; i < gaps; i++) idle_cycle();
   endtask

   task automatic send_word(input pix_t p, input logic [6:0] cw);
      lanes_t lw;
      lw = encode(p, 1'($urandom));
      for (int i = 6; i >= 0; i--)
         send_bit(cw[i], {lw[3][i], lw[2][i], lw[1][i], lw[0][i]}, p);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx.bit_valid = 1'($urandom);
      rx.clk_lane = 1'($urandom);
      rx.data_lane = 4'($urandom);
      @(posedge clk);
      model_reset();
      #1;
      record();
      reset = 1'b0;
   endtask

   task automatic applyStimulus_junk();
      send_bit(1'b0, 4'($urandom), '0);
      send_bit(1'b0, 4'($urandom), '0);
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      checks++;
      if (obs[obs.size()-1] !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs[obs.size()-1]);
      end
      idle_cycle();
      checks++;
      if (obs[obs.size()-1] !== expq[expq.size()-1]) begin
         errors++; $display("FAIL reset_idle: got %h expected %h", obs[obs.size()-1], expq[expq.size()-1]);
      end
   endtask

   task automatic test_lock();
      int start, base, npv;
      pix_t p5;
      start = obs.size();
      do_reset();
      base = obs.size();
      applyStimulus_junk();
      for (int k = 1; k <= 6; k++) begin
         pix_t p;
         p = rand_pix();
         if (k == 5) p5 = p;
         send_word(p, CLK_WORD);
      end
      checks++;
      if (obs[base+28].lk !== 1'b0 || obs[base+29].lk !== 1'b1) begin
         errors++; $display("FAIL lock_timing: got %b%b expected 01", obs[base+28].lk, obs[base+29].lk);
      end
      npv = 0;
      for (int i = start; i <= base + 35; i++) npv += int'(obs[i].pv);
      checks++;
      if (npv != 0) begin
         errors++; $display("FAIL lock_early_pix: got %0d strobes expected 0", npv);
      end
      checks++;
      if (obs[base+36].pv !== 1'b1 || obs[base+36].px !== p5) begin
         errors++; $display("FAIL lock_first_pix: got %b/%h expected 1/%h", obs[base+36].pv, obs[base+36].px, p5);
      end
      for (int i = start; i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== expq[i]) begin
            errors++; $display("FAIL lock step %0d: got %h expected %h", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_decode();
      int start;
      pix_t fixed[4];
      start = obs.size();
      fixed[0] = '{r: 8'hFF, g: 8'h00, b: 8'h00, hs: 1'b0, vs: 1'b0, de: 1'b1};
      fixed[1] = '{r: 8'h00, g: 8'h00, b: 8'hFF, hs: 1'b0, vs: 1'b0, de: 1'b1};
      fixed[2] = '{r: 8'hFF, g: 8'hFF, b: 8'hFF, hs: 1'b1, vs: 1'b1, de: 1'b1};
      fixed[3] = '{r: 8'h03, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b0, de: 1'b0};
      for (int k = 0; k < 4; k++) send_word(fixed[k], CLK_WORD);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[start+7*k+6].pv !== 1'b1 || obs[start+7*k+6].px !== fixed[k]) begin
            errors++; $display("FAIL decode_fixed%0d: got %b/%h expected 1/%h", k, obs[start+7*k+6].pv, obs[start+7*k+6].px, fixed[k]);
         end
      end
      for (int k = 0; k < 16; k++) send_word(rand_pix(), CLK_WORD);
      for (int i = start; i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== expq[i]) begin
            errors++; $display("FAIL decode step %0d: got %h expected %h", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_glitch_loss();
      int start, e0, npv, mark;
      start = obs.size();
      e0 = m_err;
      send_word(rand_pix(), CLK_WORD);
      send_word(rand_pix(), BAD_WORD);
      send_word(rand_pix(), BAD_WORD);
      send_word(rand_pix(), CLK_WORD);
      checks++;
      if (obs[obs.size()-1].lk !== 1'b1 || obs[obs.size()-1].err !== 16'(e0 + 2)) begin
         errors++; $display("FAIL glitch: got lk=%b err=%0d expected lk=1 err=%0d", obs[obs.size()-1].lk, obs[obs.size()-1].err, e0 + 2);
      end
      mark = obs.size();
      for (int k = 0; k < 3; k++) send_word(rand_pix(), BAD_WORD);
      npv = 0;
      for (int i = mark; i < obs.size(); i++) npv += int'(obs[i].pv);
      checks++;
      if (obs[obs.size()-1].lk !== 1'b0 || obs[obs.size()-1].err !== 16'(e0 + 5) || npv != 3) begin
         errors++; $display("FAIL loss: got lk=%b err=%0d pix=%0d expected lk=0 err=%0d pix=3", obs[obs.size()-1].lk, obs[obs.size()-1].err, npv, e0 + 5);
      end
      for (int k = 0; k < 6; k++) send_word(rand_pix(), CLK_WORD);
      for (int i = start; i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== expq[i]) begin
            errors++; $display("FAIL glitch_loss step %0d: got %h expected %h", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_gapped(input int mode);
      int start, last_pv;
      start = obs.size();
      do_reset();
      gap_mode = mode;
      applyStimulus_junk();
      for (int k = 0; k < 10; k++) send_word(rand_pix(), CLK_WORD);
      gap_mode = 0;
      last_pv = -1;
      for (int i = start; i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== expq[i]) begin
            errors++; $display("FAIL gapped%0d step %0d: got %h expected %h", mode, i, obs[i], expq[i]);
         end
         if (mode == 1 && obs[i].pv === 1'b1) begin
            if (last_pv >= 0) begin
               checks++;
               if (i - last_pv != 14) begin
                  errors++; $display("FAIL gapped_spacing: got %0d expected 14", i - last_pv);
               end
            end
            last_pv = i;
         end
      end
   endtask

   task automatic test_reset_midword();
      int start, s;
      lanes_t lw;
      pix_t p;
      start = obs.size();
      p = rand_pix();
      lw = encode(p, 1'b0);
      for (int i = 6; i >= 4; i--) send_bit(CLK_WORD[i], {lw[3][i], lw[2][i], lw[1][i], lw[0][i]}, p);
      do_reset();
      checks++;
      if (obs[obs.size()-1] !== '0) begin
         errors++; $display("FAIL midword_reset: got %h expected 0", obs[obs.size()-1]);
      end
      s = obs.size();
      for (int i = 3; i >= 0; i--) send_bit(CLK_WORD[i], {lw[3][i], lw[2][i], lw[1][i], lw[0][i]}, '0);
      for (int k = 0; k < 6; k++) send_word(rand_pix(), CLK_WORD);
      checks++;
      if (obs[s+30].lk !== 1'b0 || obs[s+31].lk !== 1'b1) begin
         errors++; $display("FAIL relock_timing: got %b%b expected 01", obs[s+30].lk, obs[s+31].lk);
      end
      for (int i = start; i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== expq[i]) begin
            errors++; $display("FAIL midword step %0d: got %h expected %h", i, obs[i], expq[i]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rx.bit_valid = 1'b0;
      rx.clk_lane = 1'b0;
      rx.data_lane = 4'h0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_lock();
      test_decode();
      test_glitch_loss();
      test_gapped(1);
      test_gapped(2);
      test_reset_midword();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
